sauria_job_sequencer: RTL and testbench

Hardware job sequencer between the host-side register bus and the SAURIA core's configuration port in the SAURIA demonstrator SoC. It accepts job descriptors into a small queue and runs them one at a time. For each job it writes the configuration words, writes the start register, waits for the SAURIA done interrupt under a watchdog, then clears the interrupt. It reports each job's completion with a tag and a status code.

---
 rtl/sauria_job_pkg.sv | 33 +++
 rtl/sauria_job_fifo.sv | 55 +++++
 rtl/sauria_job_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sauria_job_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sauria_job_pkg.sv
// Shared types for the SAURIA job sequencer: FSM states, completion status
// codes and the default job descriptor layout.
package sauria_job_pkg;

   localparam int DEF_CFG_WORDS = 8;
   localparam int DEF_TAG_W     = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG_WR,
      S_START_WR,
      S_WAIT_DONE,
      S_CLR_WR,
      S_REPORT
   } seq_state_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_BUS_ERR = 2'b01,
      ST_TIMEOUT = 2'b10
   } status_e;

   typedef struct packed {
      logic [DEF_TAG_W-1:0]           tag;
      logic [DEF_CFG_WORDS-1:0][31:0] cfg;
   } job_desc_t;

   // Counter/pointer width that never collapses to zero bits.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/sauria_job_fifo.sv
// Synchronous descriptor queue with a registered-storage head read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module sauria_job_fifo
   import sauria_job_pkg::*;
#(
   parameter type item_t = job_desc_t,
   parameter int  DEPTH  = 2
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  item_t push_data_i,
   input  logic  pop_i,
   output item_t head_o,
   output logic  full_o,
   output logic  empty_o
);

   localparam int AW = clog2_min1(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   item_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem[rd_ptr_q];

   // NOTE: state registers use non-blocking assignments so every flop sees
   // pre-edge values, and the reset is sampled on the clock edge only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   // NOTE: storage is deliberately not reset; count/pointers qualify it, and
   // leaving it reset-free lets it map onto plain registers or RAM.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/sauria_job_sequencer.sv
// Runs queued SAURIA jobs one at a time: config writes, start write, watchdog
// wait for the done interrupt, interrupt clear, then a tagged completion report.
module sauria_job_sequencer
   import sauria_job_pkg::*;
#(
   parameter int          NUM_CFG_WORDS  = 8,
   parameter int          JOB_DEPTH      = 2,
   parameter int          TAG_W          = 4,
   parameter logic [31:0] CFG_BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] START_ADDR     = 32'h0000_0000,
   parameter logic [31:0] START_VAL      = 32'h0000_0001,
   parameter logic [31:0] CLR_ADDR       = 32'h0000_0004,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        job_valid_i,
   output logic                        job_ready_o,
   input  logic [NUM_CFG_WORDS*32-1:0] job_cfg_i,
   input  logic [TAG_W-1:0]            job_tag_i,
   output logic                        cfg_valid_o,
   input  logic                        cfg_ready_i,
   output logic [31:0]                 cfg_addr_o,
   output logic [31:0]                 cfg_wdata_o,
   input  logic                        cfg_error_i,
   input  logic                        sauria_done_i,
   output logic                        done_valid_o,
   input  logic                        done_ready_i,
   output logic [TAG_W-1:0]            done_tag_o,
   output logic [1:0]                  done_status_o,
   output logic                        busy_o
);

   localparam int IDX_W  = clog2_min1(NUM_CFG_WORDS);
   localparam int WDOG_W = clog2_min1(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CFG_WORDS - 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef struct packed {
      logic [TAG_W-1:0]               tag;
      logic [NUM_CFG_WORDS-1:0][31:0] cfg;
   } job_entry_t;

   job_entry_t push_entry;
   job_entry_t head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_pop;

   seq_state_e        state_q, state_d;
   status_e           status_q, status_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              cfg_valid_q, cfg_valid_d;
   logic [31:0]       cfg_addr_q, cfg_addr_d;
   logic [31:0]       cfg_wdata_q, cfg_wdata_d;
   logic              wr_accept;

   assign push_entry.tag = job_tag_i;
   assign push_entry.cfg = job_cfg_i;

   sauria_job_fifo #(
      .item_t (job_entry_t),
      .DEPTH  (JOB_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (job_valid_i),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign wr_accept = cfg_valid_q && cfg_ready_i;
   assign idx_inc   = idx_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         status_q    <= ST_OK;
         idx_q       <= '0;
         wdog_q      <= '0;
         cfg_valid_q <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         idx_q       <= idx_d;
         wdog_q      <= wdog_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_wdata_q <= cfg_wdata_d;
      end
   end

   // NOTE: every always_comb output gets a default before the case so no
   // path leaves a variable unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      idx_d       = idx_q;
      wdog_d      = wdog_q;
      cfg_valid_d = cfg_valid_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_wdata_d = cfg_wdata_q;
      fifo_pop    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d     = S_CFG_WR;
               status_d    = ST_OK;
               idx_d       = '0;
               cfg_valid_d = 1'b1;
               cfg_addr_d  = CFG_BASE_ADDR;
               cfg_wdata_d = head.cfg[0];
            end
         end

         S_CFG_WR: begin
            if (wr_accept) begin
               if (cfg_error_i) begin
                  state_d     = S_REPORT;
                  status_d    = ST_BUS_ERR;
                  cfg_valid_d = 1'b0;
                  cfg_addr_d  = '0;
                  cfg_wdata_d = '0;
               end else if (idx_q == IDX_LAST) begin
                  state_d     = S_START_WR;
                  cfg_addr_d  = START_ADDR;
                  cfg_wdata_d = START_VAL;
               end else begin
                  idx_d       = idx_inc;
                  cfg_addr_d  = CFG_BASE_ADDR + (32'(idx_inc) << 2);
                  cfg_wdata_d = head.cfg[idx_inc];
               end
            end
         end

         S_START_WR: begin
            if (wr_accept) begin
               cfg_valid_d = 1'b0;
               cfg_addr_d  = '0;
               cfg_wdata_d = '0;
               if (cfg_error_i) begin
                  state_d  = S_REPORT;
                  status_d = ST_BUS_ERR;
               end else begin
                  state_d = S_WAIT_DONE;
                  wdog_d  = '0;
               end
            end
         end

         S_WAIT_DONE: begin
            if (sauria_done_i) begin
               state_d     = S_CLR_WR;
               status_d    = ST_OK;
               cfg_valid_d = 1'b1;
               cfg_addr_d  = CLR_ADDR;
               cfg_wdata_d = 32'h1;
            end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LAST)) begin
               state_d  = S_REPORT;
               status_d = ST_TIMEOUT;
            end else if (wdog_q != '1) begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         S_CLR_WR: begin
            if (wr_accept) begin
               state_d     = S_REPORT;
               cfg_valid_d = 1'b0;
               cfg_addr_d  = '0;
               cfg_wdata_d = '0;
               if (cfg_error_i) status_d = ST_BUS_ERR;
            end
         end

         S_REPORT: begin
            if (done_ready_i) begin
               state_d  = S_IDLE;
               fifo_pop = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Report fields are gated so they read as zero outside REPORT, including
   // right after reset when the queue head holds stale storage.
   assign job_ready_o   = !fifo_full;
   assign cfg_valid_o   = cfg_valid_q;
   assign cfg_addr_o    = cfg_addr_q;
   assign cfg_wdata_o   = cfg_wdata_q;
   assign done_valid_o  = (state_q == S_REPORT);
   assign done_tag_o    = (state_q == S_REPORT) ? head.tag : '0;
   assign done_status_o = (state_q == S_REPORT) ? status_q : ST_OK;
   assign busy_o        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sauria_job_sequencer.sv
// Self-checking bench for sauria_job_sequencer: randomized job data and bus
// behaviour, checked against an expected-transaction model built from job rules.
module tb_sauria_job_sequencer;

   localparam int NW    = 8;
   localparam int DEPTH = 2;
   localparam int TW    = 4;
   localparam int TMO   = 16;
   localparam logic [31:0] BASE    = 32'h0000_0000;
   localparam logic [31:0] START_A = 32'h0000_0000;
   localparam logic [31:0] START_V = 32'h0000_0001;
   localparam logic [31:0] CLR_A   = 32'h0000_0004;

   typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct packed { logic [TW-1:0] tag; logic [1:0] st; } comp_t;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              job_valid_i = 1'b0;
   logic [NW*32-1:0]  job_cfg_i = '0;
   logic [TW-1:0]     job_tag_i = '0;
   logic              cfg_ready_i = 1'b0;
   logic              cfg_error_i = 1'b0;
   logic              sauria_done_i = 1'b0;
   logic              done_ready_i = 1'b0;
   logic              job_ready_o, cfg_valid_o, done_valid_o, busy_o;
   logic [31:0]       cfg_addr_o, cfg_wdata_o;
   logic [TW-1:0]     done_tag_o;
   logic [1:0]        done_status_o;

   sauria_job_sequencer #(
      .NUM_CFG_WORDS (NW),
      .JOB_DEPTH     (DEPTH),
      .TAG_W         (TW),
      .CFG_BASE_ADDR (BASE),
      .START_ADDR    (START_A),
      .START_VAL     (START_V),
      .CLR_ADDR      (CLR_A),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
      .job_cfg_i(job_cfg_i), .job_tag_i(job_tag_i),
      .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready_i),
      .cfg_addr_o(cfg_addr_o), .cfg_wdata_o(cfg_wdata_o),
      .cfg_error_i(cfg_error_i), .sauria_done_i(sauria_done_i),
      .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
      .done_tag_o(done_tag_o), .done_status_o(done_status_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Bus environment knobs and observations
   int    ready_pct = 100, dready_pct = 100, err_arm = -1, done_delay = -1;
   int    acc_in_job = 0, done_cnt = -1, start_cyc = -1;
   logic  prev_valid = 1'b0, stall_pend = 1'b0, dstall_pend = 1'b0;
   wr_t   s_wr;
   comp_t s_comp;
   wr_t   got_wr_q[$], exp_wr_q[$];
   comp_t got_c_q[$], exp_c_q[$];
   int    comp_cyc_q[$], vrise_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus slave, interrupt source and completion consumer. Each negedge first
   // drives this cycle's inputs, then logs what the next posedge will accept.
   initial begin : bus_model
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            acc_in_job = 0; done_cnt = -1; sauria_done_i = 1'b0;
            stall_pend = 1'b0; dstall_pend = 1'b0; prev_valid = 1'b0;
            cfg_ready_i = 1'b0; cfg_error_i = 1'b0; done_ready_i = 1'b0;
         end else begin
            if (stall_pend) begin
               check("stall_valid", cfg_valid_o, 1'b1);
               check("stall_addr", cfg_addr_o, s_wr.addr);
               check("stall_data", cfg_wdata_o, s_wr.data);
            end
            if (dstall_pend) begin
               check("report_hold_valid", done_valid_o, 1'b1);
               check("report_hold_fields", {done_tag_o, done_status_o}, s_comp);
            end
            cfg_ready_i  = (int'($urandom_range(99)) < ready_pct);
            cfg_error_i  = cfg_ready_i ? (err_arm >= 0 && acc_in_job == err_arm)
                                       : 1'($urandom_range(1));
            done_ready_i = (int'($urandom_range(99)) < dready_pct);
            if (done_cnt > 0) done_cnt--;
            if (done_cnt == 0) begin
               sauria_done_i = 1'b1;
               done_cnt = -1;
            end

            if (cfg_valid_o && !prev_valid) vrise_q.push_back(cyc);
            prev_valid  = cfg_valid_o;
            stall_pend  = cfg_valid_o && !cfg_ready_i;
            s_wr        = wr_t'{cfg_addr_o, cfg_wdata_o};
            dstall_pend = done_valid_o && !done_ready_i;
            s_comp      = comp_t'{done_tag_o, done_status_o};
            if (cfg_valid_o && cfg_ready_i) begin
               got_wr_q.push_back(wr_t'{cfg_addr_o, cfg_wdata_o});
               if (cfg_error_i) begin
                  err_arm = -1;
               end else if (acc_in_job == NW) begin
                  start_cyc = cyc;
                  if (done_delay >= 0) done_cnt = done_delay;
               end else if (acc_in_job == NW + 1) begin
                  sauria_done_i = 1'b0;
               end
               acc_in_job++;
            end
            if (done_valid_o && done_ready_i) begin
               got_c_q.push_back(comp_t'{done_tag_o, done_status_o});
               comp_cyc_q.push_back(cyc);
               acc_in_job = 0;
            end
         end
      end
   end

   // Expected bus writes and completion for one job, straight from the job rules.
   task automatic model_job(input logic [TW-1:0] tag, input logic [NW*32-1:0] cfg,
                            input int err_word, input bit done_ok);
      for (int i = 0; i < NW; i++) begin
         exp_wr_q.push_back(wr_t'{BASE + 32'(4 * i), cfg[32*i +: 32]});
         if (i == err_word) begin
            exp_c_q.push_back(comp_t'{tag, 2'b01});
            return;
         end
      end
      exp_wr_q.push_back(wr_t'{START_A, START_V});
      if (!done_ok) begin
         exp_c_q.push_back(comp_t'{tag, 2'b10});
         return;
      end
      exp_wr_q.push_back(wr_t'{CLR_A, 32'h1});
      exp_c_q.push_back(comp_t'{tag, 2'b00});
   endtask

   function automatic logic [NW*32-1:0] rand_cfg();
      logic [NW*32-1:0] v;
      for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic push_job(input logic [TW-1:0] tag, input logic [NW*32-1:0] cfg, output int pcyc);
      int budget = 200;
      job_valid_i = 1'b1;
      job_tag_i   = tag;
      job_cfg_i   = cfg;
      while (!job_ready_o && budget > 0) begin
         @(negedge clk_i);
         budget--;
      end
      check("push_wait_bound", budget > 0, 1'b1);
      pcyc = cyc;
      @(negedge clk_i);
      job_valid_i = 1'b0;
   endtask

   task automatic wait_comp(input int n);
      int budget = 600;
      while (got_c_q.size() < n && budget > 0) begin
         @(negedge clk_i);
         budget--;
      end
      check("completion_wait_bound", budget > 0, 1'b1);
   endtask

   task automatic compare_all(input string name);
      check({name, "_wr_count"}, got_wr_q.size(), exp_wr_q.size());
      for (int i = 0; i < exp_wr_q.size() && i < got_wr_q.size(); i++)
         check($sformatf("%s_wr%0d", name, i), got_wr_q[i], exp_wr_q[i]);
      check({name, "_comp_count"}, got_c_q.size(), exp_c_q.size());
      for (int i = 0; i < exp_c_q.size() && i < got_c_q.size(); i++)
         check($sformatf("%s_comp%0d", name, i), got_c_q[i], exp_c_q[i]);
      got_wr_q.delete(); exp_wr_q.delete(); got_c_q.delete(); exp_c_q.delete();
      comp_cyc_q.delete(); vrise_q.delete();
   endtask

   initial begin : hang_guard
      #400000;
      $display("FAIL global_time_limit reached total=%0d", total);
      $fatal(1, "bench time limit");
   end

   initial begin : main
      logic [NW*32-1:0] c0, c1, c2;
      int p0, p1, p2, rise;

      repeat (3) @(negedge clk_i);
      check("rst_job_ready", job_ready_o, 1'b1);
      check("rst_cfg_valid", cfg_valid_o, 1'b0);
      check("rst_cfg_addr", cfg_addr_o, 32'h0);
      check("rst_cfg_wdata", cfg_wdata_o, 32'h0);
      check("rst_done_valid", done_valid_o, 1'b0);
      check("rst_done_fields", {done_tag_o, done_status_o}, '0);
      check("rst_busy", busy_o, 1'b0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Single job, no stalls, done 10 cycles after start.
      ready_pct = 100; dready_pct = 100; done_delay = 10;
      c0 = rand_cfg();
      model_job(4'h5, c0, -1, 1'b1);
      push_job(4'h5, c0, p0);
      wait_comp(1);
      check("first_write_latency", (vrise_q.size() > 0) ? vrise_q[0] - p0 : -1, 2);
      compare_all("single");

      // Random ready stalls and completion back-pressure, two queued jobs.
      ready_pct = 30; dready_pct = 50; done_delay = 3;
      c0 = rand_cfg(); c1 = rand_cfg();
      model_job(4'h1, c0, -1, 1'b1);
      model_job(4'h2, c1, -1, 1'b1);
      push_job(4'h1, c0, p0);
      push_job(4'h2, c1, p1);
      wait_comp(2);
      compare_all("stall");

      // Bus error on config word 3, then a clean job behind it.
      ready_pct = 100; dready_pct = 100; done_delay = 5; err_arm = 3;
      c0 = rand_cfg(); c1 = rand_cfg();
      model_job(4'h9, c0, 3, 1'b1);
      model_job(4'hA, c1, -1, 1'b1);
      push_job(4'h9, c0, p0);
      push_job(4'hA, c1, p1);
      wait_comp(2);
      compare_all("buserr");

      // Watchdog: done never comes.
      done_delay = -1; err_arm = -1;
      c0 = rand_cfg();
      model_job(4'h7, c0, -1, 1'b0);
      push_job(4'h7, c0, p0);
      wait_comp(1);
      check("timeout_latency", (comp_cyc_q.size() > 0) ? comp_cyc_q[0] - start_cyc : -1, TMO + 1);
      compare_all("timeout");

      // Three jobs into a two-deep queue.
      done_delay = 2;
      c0 = rand_cfg(); c1 = rand_cfg(); c2 = rand_cfg();
      model_job(4'h3, c0, -1, 1'b1);
      model_job(4'hC, c1, -1, 1'b1);
      model_job(4'hE, c2, -1, 1'b1);
      push_job(4'h3, c0, p0);
      push_job(4'hC, c1, p1);
      check("ready_low_when_full", job_ready_o, 1'b0);
      push_job(4'hE, c2, p2);
      check("third_push_after_pop", (comp_cyc_q.size() > 0) ? p2 - comp_cyc_q[0] : -1, 1);
      wait_comp(3);
      rise = -1;
      foreach (vrise_q[i]) if (rise < 0 && vrise_q[i] > comp_cyc_q[0]) rise = vrise_q[i];
      check("next_job_write_gap", rise - comp_cyc_q[0], 2);
      compare_all("fill");

      // Reset while waiting for done.
      done_delay = -1;
      c0 = rand_cfg();
      push_job(4'h6, c0, p0);
      begin
         int budget = 100;
         while (got_wr_q.size() < NW + 1 && budget > 0) begin
            @(negedge clk_i);
            budget--;
         end
         check("start_write_wait_bound", budget > 0, 1'b1);
      end
      repeat (2) @(negedge clk_i);
      check("busy_before_reset", busy_o, 1'b1);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midjob_rst_busy", busy_o, 1'b0);
      check("midjob_rst_done_valid", done_valid_o, 1'b0);
      check("midjob_rst_cfg_valid", cfg_valid_o, 1'b0);
      check("midjob_rst_job_ready", job_ready_o, 1'b1);
      rst_i = 1'b0;
      repeat (TMO + 10) @(negedge clk_i);
      check("no_report_after_rst", got_c_q.size(), 0);
      check("idle_after_rst", busy_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
